bram_sort_ctrl: RTL and testbench

Sequencer that sorts the contents of the single-port memory sort buffer in place, ascending, using bubble sort. It owns the memory's `we`/`addr`/`di` pins and reads its registered `do`. It sits beside the memory in the memory_sort top, started by a one-cycle `start` pulse and reporting `busy`/`done`. The memory has 1-cycle registered read latency and does not update `do` on write cycles.

---
 rtl/bram_sort_pkg.sv | 10 +
 rtl/bram_sort_ctrl.sv | 128 ++++++++++++
 tb/tb_bram_sort_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/bram_sort_pkg.sv
// bram_sort_pkg: shared state encoding and default geometry for the in-place BRAM bubble sorter.
package bram_sort_pkg;
    localparam int STATE_W        = 3;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 4;

    typedef enum logic [STATE_W-1:0] {
        IDLE, RD_A, RD_B, CMP, WR_A, WR_B, NEXT, DONE
    } state_t;
endpackage

// File: rtl/bram_sort_ctrl.sv
// bram_sort_ctrl: in-place ascending bubble sort over a single-port, 1-cycle-latency memory.
// Define BRAM_SORT_EARLY_EXIT_EN to stop after the first pass that performs no swap.
module bram_sort_ctrl
    import bram_sort_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_di,
    input  logic [DATA_WIDTH-1:0]   mem_do,
    output logic                    busy,
    output logic                    done,
    output logic [2*ADDR_WIDTH-1:0] swap_cnt
);
    localparam int CW = 2 * ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] i_q, i_d, last_q, last_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic                  swapped_q, swapped_d;
    logic [CW-1:0]         swap_cnt_q, swap_cnt_d;
    logic                  early_exit;

`ifdef BRAM_SORT_EARLY_EXIT_EN
    assign early_exit = !swapped_q;
`else
    assign early_exit = 1'b0;
`endif

    assign swap_cnt = swap_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            i_q        <= '0;
            last_q     <= '0;
            a_q        <= '0;
            b_q        <= '0;
            swapped_q  <= 1'b0;
            swap_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            last_q     <= last_d;
            a_q        <= a_d;
            b_q        <= b_d;
            swapped_q  <= swapped_d;
            swap_cnt_q <= swap_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        last_d     = last_q;
        a_d        = a_q;
        b_d        = b_q;
        swapped_d  = swapped_q;
        swap_cnt_d = swap_cnt_q;
        mem_we     = 1'b0;
        mem_addr   = i_q;
        mem_di     = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                busy     = 1'b0;
                mem_addr = '0;
                if (start) begin
                    i_d        = '0;
                    last_d     = '1;
                    swapped_d  = 1'b0;
                    swap_cnt_d = '0;
                    state_d    = RD_A;
                end
            end
            RD_A: state_d = RD_B;
            RD_B: begin
                mem_addr = i_q + ADDR_WIDTH'(1);
                a_d      = mem_do;
                state_d  = CMP;
            end
            // b arrives this cycle, so compare against the live read data
            CMP: begin
                b_d     = mem_do;
                state_d = (a_q > mem_do) ? WR_A : NEXT;
            end
            WR_A: begin
                mem_we  = 1'b1;
                mem_di  = b_q;
                state_d = WR_B;
            end
            WR_B: begin
                mem_we     = 1'b1;
                mem_addr   = i_q + ADDR_WIDTH'(1);
                mem_di     = a_q;
                swapped_d  = 1'b1;
                swap_cnt_d = swap_cnt_q + CW'(1);
                state_d    = NEXT;
            end
            NEXT: begin
                if (i_q < last_q - ADDR_WIDTH'(1)) begin
                    i_d     = i_q + ADDR_WIDTH'(1);
                    state_d = RD_A;
                end else if (last_q == ADDR_WIDTH'(1) || early_exit) begin
                    state_d = DONE;
                end else begin
                    last_d    = last_q - ADDR_WIDTH'(1);
                    i_d       = '0;
                    swapped_d = 1'b0;
                    state_d   = RD_A;
                end
            end
            DONE: begin
                busy     = 1'b0;
                done     = 1'b1;
                mem_addr = '0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_bram_sort_ctrl.sv
// tb_bram_sort_ctrl: directed bench for bram_sort_ctrl with a behavioural 8x4 single-port memory.
// Expectations follow BRAM_SORT_EARLY_EXIT_EN when it is defined for the build.
module tb_bram_sort_ctrl;
`ifdef BRAM_SORT_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_we;
    logic [2:0]  mem_addr;
    logic [3:0]  mem_di;
    logic [3:0]  mem_do;
    logic        busy, done;
    logic [5:0]  swap_cnt;

    logic [7:0][3:0] mem;
    logic [7:0][3:0] img;
    logic            load = 1'b0;
    int              checks = 0;
    int              errors = 0;
    int              eq_writes = 0;
    int              bc;

    always #5 clk = ~clk;

    bram_sort_ctrl #(.ADDR_WIDTH(3), .DATA_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do),
        .busy(busy), .done(done), .swap_cnt(swap_cnt)
    );

    // single-port memory: registered read, read data held on write cycles
    always @(posedge clk) begin
        if (load) mem <= img;
        else if (mem_we) mem[mem_addr] <= mem_di;
        else mem_do <= mem[mem_addr];
    end

    always @(negedge clk)
        if (mem_we && mem_di == mem[mem_addr]) eq_writes++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_mem(input logic [31:0] v);
        @(negedge clk);
        img  = v;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic run(input int restart_at, output int busy_cyc);
        bit got;
        got = 1'b0;
        busy_cyc = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            start = (k == restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk("done_seen", 32'(got), 32'd1);
        chk("busy_at_done", 32'(busy), 32'd0);
        @(negedge clk);
        chk("done_one_cycle", 32'(done), 32'd0);
    endtask

    initial begin
        int nwe;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_di", 32'(mem_di), 0);
        chk("rst_swap_cnt", 32'(swap_cnt), 0);
        rst_n = 1'b1;

        load_mem(32'h76543210);
        run(-1, bc);
        chk("sorted_mem", mem, 32'h76543210);
        chk("sorted_swaps", 32'(swap_cnt), 0);
        chk("sorted_busy", bc, EE ? 28 : 112);

        load_mem(32'h01234567);
        run(-1, bc);
        chk("rev_mem", mem, 32'h76543210);
        chk("rev_swaps", 32'(swap_cnt), 28);
        chk("rev_busy", bc, 168);
        @(negedge clk);
        chk("swap_cnt_held", 32'(swap_cnt), 28);

        load_mem(32'h89ABCDEF);
        run(-1, bc);
        chk("revhi_mem", mem, 32'hFEDCBA98);
        chk("revhi_swaps", 32'(swap_cnt), 28);
        chk("revhi_busy", bc, 168);

        load_mem(32'h00221133);
        eq_writes = 0;
        run(-1, bc);
        chk("dup_mem", mem, 32'h33221100);
        chk("dup_swaps", 32'(swap_cnt), 20);
        chk("dup_no_equal_writes", eq_writes, 0);

        load_mem(32'h01234567);
        run(10, bc);
        chk("restart_mem", mem, 32'h76543210);
        chk("restart_swaps", 32'(swap_cnt), 28);
        chk("restart_busy", bc, 168);

        load_mem(32'h76543201);
        run(-1, bc);
        chk("one_swap_mem", mem, 32'h76543210);
        chk("one_swap_cnt", 32'(swap_cnt), 1);
        chk("one_swap_busy", bc, EE ? 54 : 114);

        // abort on the third WR_A of a reverse sort, before its write lands
        load_mem(32'h01234567);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nwe = 0;
        for (int k = 0; k < 500; k++) begin
            if (mem_we) nwe++;
            if (nwe == 5) break;
            @(negedge clk);
        end
        chk("reached_wr_a", nwe, 5);
        rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(mem_we), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_swap_cnt", 32'(swap_cnt), 0);
        chk("abort_di", 32'(mem_di), 0);
        chk("abort_addr", 32'(mem_addr), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run(-1, bc);
        chk("resort_mem", mem, 32'h76543210);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
